// File: rtl/seq_shift_register.sv
// seq_shift_register: multi-bit shift register with a counted run sequencer (start/busy/done) and a registered shifted-out field.
//   params: WIDTH register width, STEP bits per step, CNT_W shift_count width
//   in : clk, rst (sync, active-high), clear, load, parallel_in, start, shift_count,
//        step_en, dir (0 left / 1 right), mode (00 fill, 01 arith, 10 rotate, 11 fill), new_bits
//   out: parallel_out, shifted_out, busy, done (one-cycle pulse)
module seq_shift_register #(
  parameter int WIDTH = 32,
  parameter int STEP = 1,
  parameter int CNT_W = $clog2(WIDTH / STEP + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic             start,
  input  logic [CNT_W-1:0] shift_count,
  input  logic             step_en,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic [STEP-1:0]  new_bits,
  output logic [WIDTH-1:0] parallel_out,
  output logic [STEP-1:0]  shifted_out,
  output logic             busy,
  output logic             done
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] cnt;
  logic run_dir, s_dir, do_step;
  logic [1:0] run_mode, s_mode;
  logic [STEP-1:0] out, fill;
  logic [WIDTH-1:0] shifted;
  // a run uses the dir/mode latched at start; manual steps use the live inputs
  always_comb begin
    s_dir = state == RUN ? run_dir : dir;
    s_mode = state == RUN ? run_mode : mode;
    out = s_dir ? parallel_out[STEP-1:0] : parallel_out[WIDTH-1 -: STEP];
    fill = s_mode == 2'b10 ? out :
           s_mode == 2'b01 ? (s_dir ? {STEP{parallel_out[WIDTH-1]}} : '0) : new_bits;
    shifted = s_dir ? {fill, parallel_out[WIDTH-1:STEP]} : {parallel_out[WIDTH-STEP-1:0], fill};
    do_step = state == RUN || (!load && !start && step_en);
  end
  always_comb begin
    state_n = state;
    if (state == IDLE && !load && start && shift_count != '0) state_n = RUN;
    if (state == RUN && cnt == CNT_W'(1)) state_n = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state <= IDLE;
      cnt <= '0;
      run_dir <= 1'b0;
      run_mode <= 2'b00;
      parallel_out <= '0;
      shifted_out <= '0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      done <= 1'b0;
      if (state == RUN) begin
        cnt <= cnt - CNT_W'(1);
        done <= cnt == CNT_W'(1);
      end else if (load) parallel_out <= parallel_in;
      else if (start) begin
        run_dir <= dir;
        run_mode <= mode;
        cnt <= shift_count;
        done <= shift_count == '0;
      end
      if (do_step) begin
        parallel_out <= shifted;
        shifted_out <= out;
      end
    end
  end
  assign busy = state == RUN;
endmodule

// File: tb/tb_seq_shift_register.sv
// tb_seq_shift_register: directed scenarios plus randomized traffic checked each cycle against a behavioural model.
module tb_seq_shift_register;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1, clear = 1'b0, load = 1'b0, start = 1'b0, step_en = 1'b0, dir = 1'b0;
  logic [1:0] mode = 2'b00, nb = 2'b00, so;
  logic [7:0] pin = 8'h00, po;
  logic [2:0] sc = 3'd0;
  logic busy, done;
  seq_shift_register #(.WIDTH(8), .STEP(2)) dut (
    .clk(clk), .rst(rst), .clear(clear), .load(load), .parallel_in(pin), .start(start),
    .shift_count(sc), .step_en(step_en), .dir(dir), .mode(mode), .new_bits(nb),
    .parallel_out(po), .shifted_out(so), .busy(busy), .done(done));
  logic load32 = 1'b0, start32 = 1'b0, se32 = 1'b0, dir32 = 1'b0, nb32 = 1'b0;
  logic [1:0] mode32 = 2'b00;
  logic [31:0] pin32 = '0, po32;
  logic [5:0] sc32 = '0;
  logic so32, busy32, done32;
  seq_shift_register #(.WIDTH(32), .STEP(1)) dut32 (
    .clk(clk), .rst(rst), .clear(clear), .load(load32), .parallel_in(pin32), .start(start32),
    .shift_count(sc32), .step_en(se32), .dir(dir32), .mode(mode32), .new_bits(nb32),
    .parallel_out(po32), .shifted_out(so32), .busy(busy32), .done(done32));
  int errors = 0, checks = 0;
  logic on = 1'b0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic tick;
    @(negedge clk);
  endtask
  // model: register value, last expelled bits, steps remaining in the run
  logic [7:0] m_r = '0;
  logic [1:0] m_so = '0, m_mode = '0;
  logic m_dir = 1'b0, m_done = 1'b0;
  int m_left = 0;
  function automatic logic [9:0] mstep(input logic [7:0] r, input logic d, input logic [1:0] m, input logic [1:0] b);
    logic [7:0] n;
    logic [1:0] o;
    o = d ? 2'(r % 8'd4) : 2'(r / 8'd64);
    if (m == 2'd2) n = d ? 8'((r >> 2) | (r << 6)) : 8'((r << 2) | (r >> 6));
    else if (m == 2'd1) n = d ? 8'($signed(r) >>> 2) : 8'(r << 2);
    else n = d ? 8'((r >> 2) | (8'(b) << 6)) : 8'((r << 2) | 8'(b));
    return {o, n};
  endfunction
  always @(posedge clk) begin
    logic [9:0] t;
    if (rst || clear) begin
      m_r = '0; m_so = '0; m_done = 1'b0; m_left = 0;
    end else if (m_left > 0) begin
      t = mstep(m_r, m_dir, m_mode, nb);
      {m_so, m_r} = t;
      m_left--;
      m_done = m_left == 0;
    end else begin
      m_done = 1'b0;
      if (load) m_r = pin;
      else if (start) begin
        m_dir = dir; m_mode = mode; m_left = int'(sc); m_done = sc == 3'd0;
      end else if (step_en) begin
        t = mstep(m_r, dir, mode, nb);
        {m_so, m_r} = t;
      end
    end
  end
  always @(negedge clk) if (on) begin
    chk("parallel_out", 32'(po), 32'(m_r));
    chk("shifted_out", 32'(so), 32'(m_so));
    chk("busy", 32'(busy), 32'(m_left > 0));
    chk("done", 32'(done), 32'(m_done));
  end
  initial begin
    tick;
    rst = 1'b0;
    on = 1'b1;
    chk("rst po32", po32, 32'h0);
    chk("rst busy32", 32'(busy32), 32'h0);
    // 32x1: right shift filling ones
    load32 = 1'b1; pin32 = 32'h0000_00F0; tick; load32 = 1'b0;
    start32 = 1'b1; sc32 = 6'd4; dir32 = 1'b1; mode32 = 2'b00; nb32 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick; start32 = 1'b0;
      chk("run32 busy", 32'(busy32), 32'h1);
    end
    tick;
    chk("run32 po", po32, 32'hF000_000F);
    chk("run32 so", 32'(so32), 32'h0);
    chk("run32 busy end", 32'(busy32), 32'h0);
    chk("run32 done", 32'(done32), 32'h1);
    tick;
    chk("run32 done off", 32'(done32), 32'h0);
    // 8x2 arithmetic right, then restart in the done cycle with rotate left
    load = 1'b1; pin = 8'h96; tick; load = 1'b0;
    start = 1'b1; sc = 3'd2; dir = 1'b1; mode = 2'b01; tick; start = 1'b0;
    chk("arith busy", 32'(busy), 32'h1);
    tick; chk("arith step1", 32'(po), 32'hE5);
    tick; chk("arith final", 32'(po), 32'hF9);
    chk("arith so", 32'(so), 32'h1);
    chk("arith done", 32'(done), 32'h1);
    start = 1'b1; sc = 3'd1; dir = 1'b0; mode = 2'b10; tick; start = 1'b0;
    chk("restart busy", 32'(busy), 32'h1);
    tick; chk("restart po", 32'(po), 32'hE7);
    chk("restart so", 32'(so), 32'h3);
    // rotate left x3
    load = 1'b1; pin = 8'h96; tick; load = 1'b0;
    start = 1'b1; sc = 3'd3; dir = 1'b0; mode = 2'b10; tick; start = 1'b0;
    tick; tick; tick;
    chk("rot po", 32'(po), 32'hA5);
    chk("rot so", 32'(so), 32'h1);
    // clear mid-run, load/start during busy ignored
    load = 1'b1; pin = 8'h3C; tick; load = 1'b0;
    start = 1'b1; sc = 3'd4; dir = 1'b0; mode = 2'b00; nb = 2'b00; tick;
    load = 1'b1; pin = 8'hFF; sc = 3'd1; tick;
    chk("busy ignore", 32'(po), 32'hF0);
    load = 1'b0; start = 1'b0; clear = 1'b1; tick; clear = 1'b0;
    chk("clear po", 32'(po), 32'h0);
    chk("clear busy", 32'(busy), 32'h0);
    chk("clear done", 32'(done), 32'h0);
    tick; chk("clear no done", 32'(done), 32'h0);
    // zero-length run, then a manual step
    load = 1'b1; pin = 8'h5A; tick; load = 1'b0;
    start = 1'b1; sc = 3'd0; tick; start = 1'b0;
    chk("n0 done", 32'(done), 32'h1);
    chk("n0 busy", 32'(busy), 32'h0);
    chk("n0 po", 32'(po), 32'h5A);
    load = 1'b1; pin = 8'h01; tick; load = 1'b0;
    step_en = 1'b1; dir = 1'b0; mode = 2'b00; nb = 2'b11; tick; step_en = 1'b0;
    chk("step po", 32'(po), 32'h07);
    chk("step so", 32'(so), 32'h0);
    // reset mid-run, then a one-step run
    load = 1'b1; pin = 8'h96; tick; load = 1'b0;
    start = 1'b1; sc = 3'd4; dir = 1'b1; mode = 2'b10; tick; start = 1'b0;
    tick; tick; rst = 1'b1; tick; rst = 1'b0;
    chk("rst po", 32'(po), 32'h0);
    chk("rst busy", 32'(busy), 32'h0);
    start = 1'b1; sc = 3'd1; dir = 1'b0; mode = 2'b00; nb = 2'b10; tick; start = 1'b0;
    chk("post rst busy", 32'(busy), 32'h1);
    tick;
    chk("post rst po", 32'(po), 32'h02);
    chk("post rst done", 32'(done), 32'h1);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      rst = $urandom_range(63) == 0;
      clear = $urandom_range(31) == 0;
      load = $urandom_range(3) == 0;
      start = $urandom_range(3) == 0;
      step_en = $urandom_range(2) == 0;
      dir = 1'($urandom);
      mode = 2'($urandom);
      nb = 2'($urandom);
      pin = 8'($urandom);
      sc = 3'($urandom);
      tick;
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
